// File: rtl/acc_stack_rf.sv
// Accumulator plus BAK stack for the TIS-100 execution node: signed saturating
// WRITE/ADD/SUB/NEG on ACC, SAV/SWP/POP against a DEPTH-entry stack, err/sat pulses.
module acc_stack_rf #(
  parameter int WIDTH   = 11,
  parameter int DEPTH   = 4,
  parameter int SAT_MAX = 999
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       op_valid,
  input  logic [2:0]                 op,
  input  logic signed [WIDTH-1:0]    operand,
  output logic signed [WIDTH-1:0]    acc,
  output logic signed [WIDTH-1:0]    bak,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err,
  output logic                       sat
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic signed [WIDTH:0] POS_LIM = (WIDTH+1)'(SAT_MAX);
  localparam logic signed [WIDTH:0] NEG_LIM = -POS_LIM;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WRITE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_NEG   = 3'd4,
    OP_SAV   = 3'd5,
    OP_SWP   = 3'd6,
    OP_POP   = 3'd7
  } op_e;

  // Top of stack lives in stk[0]; push/pop shift the whole array so no pointer indexing is needed.
  logic signed [WIDTH-1:0] stk [DEPTH];

  logic signed [WIDTH:0]   acc_ext, opd_ext, sum_ext, dif_ext;
  logic signed [WIDTH-1:0] wr_val, add_val, sub_val;
  logic                    wr_sat, add_sat, sub_sat;
  op_e                     cur_op;

  function automatic logic [WIDTH:0] clamp(input logic signed [WIDTH:0] x);
    logic signed [WIDTH:0] y;
    logic                  s;
    s = 1'b1;
    if (x > POS_LIM)      y = POS_LIM;
    else if (x < NEG_LIM) y = NEG_LIM;
    else begin
      y = x;
      s = 1'b0;
    end
    return {s, y[WIDTH-1:0]};
  endfunction

  always_comb begin
    cur_op  = op_e'(op);
    acc_ext = {acc[WIDTH-1], acc};
    opd_ext = {operand[WIDTH-1], operand};
    sum_ext = acc_ext + opd_ext;
    dif_ext = acc_ext - opd_ext;
    {wr_sat,  wr_val}  = clamp(opd_ext);
    {add_sat, add_val} = clamp(sum_ext);
    {sub_sat, sub_val} = clamp(dif_ext);
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign bak   = empty ? '0 : stk[0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc   <= '0;
      count <= '0;
      err   <= 1'b0;
      sat   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else begin
      err <= 1'b0;
      sat <= 1'b0;
      if (op_valid) begin
        unique case (cur_op)
          OP_WRITE: begin
            acc <= wr_val;
            sat <= wr_sat;
          end
          OP_ADD: begin
            acc <= add_val;
            sat <= add_sat;
          end
          OP_SUB: begin
            acc <= sub_val;
            sat <= sub_sat;
          end
          OP_NEG: acc <= -acc;
          OP_SAV: begin
            if (full) err <= 1'b1;
            else begin
              for (int unsigned i = DEPTH - 1; i > 0; i--) stk[i] <= stk[i-1];
              stk[0] <= acc;
              count  <= count + 1'b1;
            end
          end
          OP_SWP: begin
            // Empty stack: bak reads 0, so the same exchange also covers the implicit push.
            acc    <= bak;
            stk[0] <= acc;
            if (empty) count <= CW'(1);
          end
          OP_POP: begin
            if (empty) err <= 1'b1;
            else begin
              acc <= stk[0];
              for (int unsigned i = 0; i + 1 < DEPTH; i++) stk[i] <= stk[i+1];
              count <= count - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acc_stack_rf.sv
// Directed self-checking bench for acc_stack_rf with default parameters.
module tb_acc_stack_rf;

  logic                     clk = 1'b0;
  logic                     nrst = 1'b0;
  logic                     op_valid = 1'b0;
  logic [2:0]               op = 3'd0;
  logic signed [10:0]       operand = '0;
  logic signed [10:0]       acc, bak;
  logic [2:0]               count;
  logic                     full, empty, err, sat;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] NOP = 3'd0, WRITE = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         NEG = 3'd4, SAV = 3'd5, SWP = 3'd6, POP = 3'd7;

  acc_stack_rf #(.WIDTH(11), .DEPTH(4), .SAT_MAX(999)) dut (
    .clk(clk), .nrst(nrst), .op_valid(op_valid), .op(op), .operand(operand),
    .acc(acc), .bak(bak), .count(count), .full(full), .empty(empty),
    .err(err), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input int v, input logic vld = 1'b1);
    @(negedge clk);
    op_valid = vld;
    op       = o;
    operand  = 11'(v);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int a, input int b, input int c,
                           input int e, input int s);
    chk({tag, ".acc"},   int'(acc), a);
    chk({tag, ".bak"},   int'(bak), b);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".full"},  int'(full), (c == 4) ? 1 : 0);
    chk({tag, ".empty"}, int'(empty), (c == 0) ? 1 : 0);
    chk({tag, ".err"},   int'(err), e);
    chk({tag, ".sat"},   int'(sat), s);
  endtask

  initial begin
    #12;
    chk_state("reset", 0, 0, 0, 0, 0);
    nrst = 1'b1;

    do_op(WRITE, 500);   chk_state("wr500",   500, 0, 0, 0, 0);
    do_op(ADD, 600);     chk_state("add600",  999, 0, 0, 0, 1);
    do_op(NOP, 0);       chk_state("nop_sat", 999, 0, 0, 0, 0);
    do_op(SUB, 999);     chk_state("sub999",  0, 0, 0, 0, 0);
    do_op(WRITE, -1000); chk_state("wr_m1000", -999, 0, 0, 0, 1);
    do_op(WRITE, -999);  chk_state("wr_m999", -999, 0, 0, 0, 0);
    do_op(SUB, 500);     chk_state("sub_low", -999, 0, 0, 0, 1);
    do_op(NEG, 0);       chk_state("neg",     999, 0, 0, 0, 0);
    do_op(ADD, -1024);   chk_state("add_m1024", -25, 0, 0, 0, 0);

    for (int k = 1; k <= 4; k++) begin
      do_op(WRITE, k);
      do_op(SAV, 0);
      chk_state($sformatf("fill%0d", k), k, k, k, 0, 0);
    end
    do_op(SAV, 0);       chk_state("sav_full", 4, 4, 4, 1, 0);
    do_op(NOP, 0);       chk_state("nop_err",  4, 4, 4, 0, 0);

    for (int k = 4; k >= 1; k--) begin
      do_op(POP, 0);
      chk_state($sformatf("pop%0d", k), k, (k > 1) ? k - 1 : 0, k - 1, 0, 0);
    end
    do_op(POP, 0);       chk_state("pop_empty", 1, 0, 0, 1, 0);

    do_op(WRITE, 7);     chk_state("wr7",  7, 0, 0, 0, 0);
    do_op(SWP, 0);       chk_state("swp1", 0, 7, 1, 0, 0);
    do_op(SWP, 0);       chk_state("swp2", 7, 0, 1, 0, 0);

    do_op(WRITE, 1023);  chk_state("wr1023", 999, 0, 1, 0, 1);
    do_op(WRITE, 123, 1'b0);
    chk_state("invalid", 999, 0, 1, 0, 0);

    do_op(SAV, 0);
    do_op(SAV, 0);
    do_op(WRITE, -50);   chk_state("pre_rst", -50, 999, 3, 0, 0);
    do_op(POP, 0);       chk_state("pop_mid", 999, 999, 2, 0, 0);
    do_op(WRITE, -50);
    do_op(SAV, 0);       chk_state("sav_mid", -50, -50, 3, 0, 0);

    @(negedge clk);
    op_valid = 1'b1;
    op       = WRITE;
    operand  = 11'sd77;
    #2 nrst = 1'b0;
    #1 chk_state("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_state("held_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    op_valid = 1'b0;
    nrst = 1'b1;
    do_op(WRITE, 5);     chk_state("post_rst", 5, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
